// File: rtl/rect_plotter.sv
`timescale 1ns/1ps
// Command-driven rectangle rasteriser: clips a rectangle to the screen and emits one
// pixel per clock towards vga_adapter, then pulses done for a single cycle.
module rect_plotter #(
   parameter int X_W       = 8,
   parameter int Y_W       = 7,
   parameter int COLOUR_W  = 3,
   parameter int SCREEN_W  = 160,
   parameter int SCREEN_H  = 120,
   parameter int BG_COLOUR = 0
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [1:0]          cmd_mode,
   input  logic [X_W-1:0]      cmd_x,
   input  logic [Y_W-1:0]      cmd_y,
   input  logic [X_W-1:0]      cmd_w,
   input  logic [Y_W-1:0]      cmd_h,
   input  logic [COLOUR_W-1:0] cmd_colour,
   output logic [X_W-1:0]      vga_x,
   output logic [Y_W-1:0]      vga_y,
   output logic [COLOUR_W-1:0] vga_colour,
   output logic                enable_plot,
   output logic                busy,
   output logic                done
);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   localparam logic [1:0]          MODE_ERASE   = 2'd1;
   localparam logic [1:0]          MODE_FILL    = 2'd2;
   localparam logic [1:0]          MODE_OUTLINE = 2'd3;
   localparam logic [X_W:0]        SCR_W        = (X_W+1)'(SCREEN_W);
   localparam logic [Y_W:0]        SCR_H        = (Y_W+1)'(SCREEN_H);
   localparam logic [X_W:0]        ONE_XE       = (X_W+1)'(1);
   localparam logic [Y_W:0]        ONE_YE       = (Y_W+1)'(1);
   localparam logic [COLOUR_W-1:0] BG           = COLOUR_W'(BG_COLOUR);

   state_t                state_reg, state_next;
   logic [1:0]            mode_reg, mode_next;
   logic [X_W-1:0]        x0_reg, x0_next;
   logic [Y_W-1:0]        y0_reg, y0_next;
   logic [X_W:0]          xe_reg, xe_next, x_last_reg, x_last_next;
   logic [Y_W:0]          ye_reg, ye_next, y_last_reg, y_last_next;
   logic [X_W-1:0]        vga_x_reg, vga_x_next;
   logic [Y_W-1:0]        vga_y_reg, vga_y_next;
   logic [COLOUR_W-1:0]   vga_colour_reg, vga_colour_next;
   logic                  enable_plot_reg, enable_plot_next;
   logic                  done_reg, done_next;

   // Command decode: FILL overrides the geometry with the whole screen.
   logic [X_W-1:0]        rect_x, rect_w;
   logic [Y_W-1:0]        rect_y, rect_h;
   logic [X_W:0]          sum_x, clip_xe;
   logic [Y_W:0]          sum_y, clip_ye;
   logic                  rect_empty;
   logic [COLOUR_W-1:0]   pix_colour;

   assign rect_x     = (cmd_mode == MODE_FILL) ? '0 : cmd_x;
   assign rect_y     = (cmd_mode == MODE_FILL) ? '0 : cmd_y;
   assign rect_w     = (cmd_mode == MODE_FILL) ? X_W'(SCREEN_W) : cmd_w;
   assign rect_h     = (cmd_mode == MODE_FILL) ? Y_W'(SCREEN_H) : cmd_h;
   assign sum_x      = {1'b0, rect_x} + {1'b0, rect_w};
   assign sum_y      = {1'b0, rect_y} + {1'b0, rect_h};
   assign clip_xe    = (sum_x > SCR_W) ? SCR_W : sum_x;
   assign clip_ye    = (sum_y > SCR_H) ? SCR_H : sum_y;
   assign rect_empty = (rect_w == '0) || (rect_h == '0) ||
                       ({1'b0, rect_x} >= SCR_W) || ({1'b0, rect_y} >= SCR_H);
   assign pix_colour = (cmd_mode == MODE_ERASE) ? BG : cmd_colour;

   // Scan stepping against the clipped end bounds.
   logic           x_wrap, y_wrap;
   logic [X_W-1:0] step_x;
   logic [Y_W-1:0] step_y;
   logic           step_edge;

   assign x_wrap    = (({1'b0, vga_x_reg} + ONE_XE) == xe_reg);
   assign y_wrap    = (({1'b0, vga_y_reg} + ONE_YE) == ye_reg);
   assign step_x    = x_wrap ? x0_reg : vga_x_reg + X_W'(1);
   assign step_y    = x_wrap ? vga_y_reg + Y_W'(1) : vga_y_reg;
   // Outline edges are judged against the unclipped rectangle.
   assign step_edge = (step_x == x0_reg) || ({1'b0, step_x} == x_last_reg) ||
                      (step_y == y0_reg) || ({1'b0, step_y} == y_last_reg);

   always_comb begin
      state_next       = state_reg;
      mode_next        = mode_reg;
      x0_next          = x0_reg;
      y0_next          = y0_reg;
      xe_next          = xe_reg;
      ye_next          = ye_reg;
      x_last_next      = x_last_reg;
      y_last_next      = y_last_reg;
      vga_x_next       = vga_x_reg;
      vga_y_next       = vga_y_reg;
      vga_colour_next  = vga_colour_reg;
      enable_plot_next = 1'b0;
      done_next        = 1'b0;
      case (state_reg)
         IDLE: begin
            if (cmd_valid) begin
               mode_next   = cmd_mode;
               x0_next     = rect_x;
               y0_next     = rect_y;
               xe_next     = clip_xe;
               ye_next     = clip_ye;
               x_last_next = sum_x - ONE_XE;
               y_last_next = sum_y - ONE_YE;
               if (rect_empty) begin
                  state_next = DONE;
                  done_next  = 1'b1;
               end else begin
                  // First pixel is the top-left corner, which is always plotted.
                  state_next       = SCAN;
                  vga_x_next       = rect_x;
                  vga_y_next       = rect_y;
                  vga_colour_next  = pix_colour;
                  enable_plot_next = 1'b1;
               end
            end
         end
         SCAN: begin
            if (x_wrap && y_wrap) begin
               state_next = DONE;
               done_next  = 1'b1;
            end else begin
               vga_x_next       = step_x;
               vga_y_next       = step_y;
               enable_plot_next = (mode_reg != MODE_OUTLINE) || step_edge;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_reg       <= IDLE;
         mode_reg        <= '0;
         x0_reg          <= '0;
         y0_reg          <= '0;
         xe_reg          <= '0;
         ye_reg          <= '0;
         x_last_reg      <= '0;
         y_last_reg      <= '0;
         vga_x_reg       <= '0;
         vga_y_reg       <= '0;
         vga_colour_reg  <= '0;
         enable_plot_reg <= 1'b0;
         done_reg        <= 1'b0;
      end else begin
         state_reg       <= state_next;
         mode_reg        <= mode_next;
         x0_reg          <= x0_next;
         y0_reg          <= y0_next;
         xe_reg          <= xe_next;
         ye_reg          <= ye_next;
         x_last_reg      <= x_last_next;
         y_last_reg      <= y_last_next;
         vga_x_reg       <= vga_x_next;
         vga_y_reg       <= vga_y_next;
         vga_colour_reg  <= vga_colour_next;
         enable_plot_reg <= enable_plot_next;
         done_reg        <= done_next;
      end
   end

   assign cmd_ready   = (state_reg == IDLE);
   assign busy        = (state_reg == SCAN) || (state_reg == DONE);
   assign vga_x       = vga_x_reg;
   assign vga_y       = vga_y_reg;
   assign vga_colour  = vga_colour_reg;
   assign enable_plot = enable_plot_reg;
   assign done        = done_reg;

endmodule

// File: tb/tb_rect_plotter.sv
`timescale 1ns/1ps
// Bench for rect_plotter: directed and random commands checked pixel-by-pixel against
// a loop-based model of the clipped raster.
module tb_rect_plotter;

   localparam int X_W       = 8;
   localparam int Y_W       = 7;
   localparam int COLOUR_W  = 3;
   localparam int SCREEN_W  = 160;
   localparam int SCREEN_H  = 120;
   localparam int BG_COLOUR = 0;

   logic                clock = 1'b0;
   logic                reset_n;
   logic                cmd_valid;
   logic                cmd_ready;
   logic [1:0]          cmd_mode;
   logic [X_W-1:0]      cmd_x;
   logic [Y_W-1:0]      cmd_y;
   logic [X_W-1:0]      cmd_w;
   logic [Y_W-1:0]      cmd_h;
   logic [COLOUR_W-1:0] cmd_colour;
   logic [X_W-1:0]      vga_x;
   logic [Y_W-1:0]      vga_y;
   logic [COLOUR_W-1:0] vga_colour;
   logic                enable_plot;
   logic                busy;
   logic                done;

   int total = 0;
   int bad   = 0;
   int last_x = 0, last_y = 0, last_col = 0;
   int ex_q[$], ey_q[$], ec_q[$], en_q[$];

   always #5 clock = ~clock;

   rect_plotter #(
      .X_W(X_W), .Y_W(Y_W), .COLOUR_W(COLOUR_W),
      .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .BG_COLOUR(BG_COLOUR)
   ) dut (
      .clock(clock), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
      .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
      .cmd_colour(cmd_colour),
      .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
      .enable_plot(enable_plot), .busy(busy), .done(done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_x"}, vga_x, 0);
      check({tag, "_y"}, vga_y, 0);
      check({tag, "_col"}, vga_colour, 0);
      check({tag, "_en"}, enable_plot, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_ready"}, cmd_ready, 1);
   endtask

   // Expected pixel list: every point of the clipped rectangle in raster order.
   task automatic build_model(input int mode, input int x, input int y, input int w,
                              input int h, input int col);
      int rx, ry, rw, rh, xe, ye, c;
      ex_q.delete(); ey_q.delete(); ec_q.delete(); en_q.delete();
      rx = x; ry = y; rw = w; rh = h;
      if (mode == 2) begin
         rx = 0; ry = 0; rw = SCREEN_W; rh = SCREEN_H;
      end
      xe = (rx + rw < SCREEN_W) ? rx + rw : SCREEN_W;
      ye = (ry + rh < SCREEN_H) ? ry + rh : SCREEN_H;
      c  = (mode == 1) ? BG_COLOUR : col;
      for (int yy = ry; yy < ye; yy++) begin
         for (int xx = rx; xx < xe; xx++) begin
            ex_q.push_back(xx);
            ey_q.push_back(yy);
            ec_q.push_back(c);
            en_q.push_back((mode != 3 || xx == rx || xx == rx + rw - 1 ||
                            yy == ry || yy == ry + rh - 1) ? 1 : 0);
         end
      end
   endtask

   task automatic run_cmd(input int mode, input int x, input int y, input int w,
                          input int h, input int col);
      int n, plots;
      build_model(mode, x, y, w, h, col);
      n = ex_q.size();
      plots = 0;
      @(negedge clock);
      cmd_mode   = mode[1:0];
      cmd_x      = x[X_W-1:0];
      cmd_y      = y[Y_W-1:0];
      cmd_w      = w[X_W-1:0];
      cmd_h      = h[Y_W-1:0];
      cmd_colour = col[COLOUR_W-1:0];
      cmd_valid  = 1'b1;
      check("ready_before_cmd", cmd_ready, 1);
      @(posedge clock); #1;
      cmd_valid = 1'b0;
      for (int k = 0; k < n; k++) begin
         check("pix_x", vga_x, ex_q[k]);
         check("pix_y", vga_y, ey_q[k]);
         check("pix_col", vga_colour, ec_q[k]);
         check("pix_en", enable_plot, en_q[k]);
         check("pix_busy", busy, 1);
         check("pix_done", done, 0);
         plots += en_q[k];
         @(posedge clock); #1;
      end
      if (n > 0) begin
         last_x = ex_q[n-1];
         last_y = ey_q[n-1];
         last_col = ec_q[n-1];
      end
      check("done_pulse", done, 1);
      check("done_en", enable_plot, 0);
      check("done_busy", busy, 1);
      check("done_ready", cmd_ready, 0);
      check("done_hold_x", vga_x, last_x);
      check("done_hold_y", vga_y, last_y);
      check("done_hold_col", vga_colour, last_col);
      @(posedge clock); #1;
      check("after_done", done, 0);
      check("after_ready", cmd_ready, 1);
      check("after_busy", busy, 0);
      check("after_en", enable_plot, 0);
      check("after_hold_x", vga_x, last_x);
      $display("cmd mode=%0d x=%0d y=%0d w=%0d h=%0d col=%0d pixels=%0d plots=%0d",
               mode, x, y, w, h, col, n, plots);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired before the test completed");
      $fatal(1, "watchdog");
   end

   initial begin
      int m, x, y, w, h, c;
      reset_n = 1'b0;
      cmd_valid = 1'b0;
      cmd_mode = '0; cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_colour = '0;
      repeat (2) @(posedge clock);
      #1;
      check_idle_outputs("reset");
      reset_n = 1'b1;

      run_cmd(0, 10, 20, 3, 2, 5);          // basic draw
      run_cmd(1, 158, 118, 5, 5, 7);        // erase clipped to 2x2
      run_cmd(2, 77, 33, 9, 9, 2);          // full-screen fill
      run_cmd(3, 0, 0, 4, 3, 4);            // outline with two interior pixels
      run_cmd(0, 5, 5, 0, 3, 3);            // zero width
      run_cmd(0, 200, 5, 4, 3, 3);          // off-screen x
      run_cmd(3, 150, 100, 255, 30, 6);     // x0+w overflows X_W bits
      run_cmd(0, 159, 119, 1, 1, 1);        // last screen pixel

      // Reset while pixel 3 of a 4x4 draw is on the outputs.
      @(negedge clock);
      cmd_mode = 2'd0; cmd_x = 8'd30; cmd_y = 7'd40; cmd_w = 8'd4; cmd_h = 7'd4;
      cmd_colour = 3'd6; cmd_valid = 1'b1;
      @(posedge clock); #1;
      cmd_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check("abort_pix_x", vga_x, 30 + k);
         @(posedge clock); #1;
      end
      check("abort_pix3_x", vga_x, 33);
      check("abort_pix3_en", enable_plot, 1);
      reset_n = 1'b0;
      cmd_mode = 2'd0; cmd_x = 8'd1; cmd_y = 7'd1; cmd_w = 8'd2; cmd_h = 7'd2;
      cmd_valid = 1'b1;
      @(posedge clock); #1;
      check_idle_outputs("abort_reset");
      @(posedge clock); #1;
      check_idle_outputs("discard_in_reset");
      reset_n = 1'b1;
      cmd_valid = 1'b0;
      last_x = 0; last_y = 0; last_col = 0;
      @(posedge clock); #1;
      check_idle_outputs("post_reset_idle");
      run_cmd(0, 1, 1, 2, 2, 3);

      for (int i = 0; i < 40; i++) begin
         m = $urandom_range(0, 3);
         if (m == 2) m = 3;
         x = $urandom_range(0, 175);
         y = $urandom_range(0, 127);
         w = $urandom_range(0, 14);
         h = $urandom_range(0, 9);
         c = $urandom_range(0, 7);
         if ($urandom_range(0, 4) == 0) w = $urandom_range(100, 255);
         run_cmd(m, x, y, w, h, c);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
